// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the requester-side and TX-core-side handshake of the UART TX
//   arbiter. Signal names match the arbiter's historical flat port names.
//   slave  : the arbiter (consumes requests and TX ready; drives everything else)
//   master : the environment (requesters + TX core)
//   i_req_valid/i_req_data/i_req_last : per-requester byte stream, requester k
//                                       data at [k*P_DATA_WIDTH +: P_DATA_WIDTH]
//   o_req_ready                       : per-requester ready
//   o_tx_valid/o_tx_data/i_tx_ready   : byte handshake to the UART TX core
//   o_grant/o_busy/o_timeout          : status
interface uart_tx_arbiter_if #(
  parameter int P_NUM_REQ    = 3,
  parameter int P_DATA_WIDTH = 8
);
  logic [P_NUM_REQ-1:0]              i_req_valid;
  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_data;
  logic [P_NUM_REQ-1:0]              i_req_last;
  logic [P_NUM_REQ-1:0]              o_req_ready;
  logic                              o_tx_valid;
  logic [P_DATA_WIDTH-1:0]           o_tx_data;
  logic                              i_tx_ready;
  logic [P_NUM_REQ-1:0]              o_grant;
  logic                              o_busy;
  logic                              o_timeout;

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_tx_ready,
    output o_req_ready, o_tx_valid, o_tx_data, o_grant, o_busy, o_timeout
  );

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_tx_ready,
    input  o_req_ready, o_tx_valid, o_tx_data, o_grant, o_busy, o_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART TX byte stream between P_NUM_REQ byte sources using
//   round-robin arbitration with packet lock. Each grant ends on the last
//   byte of a packet, after P_BURST_MAX accepted bytes, or after
//   P_IDLE_TIMEOUT cycles with the grantee's valid low. Bytes reach the TX
//   core through a one-entry registered output stage.
//   S_AXI_ACLK    : clock
//   S_AXI_ARESETN : asynchronous active-low reset
//   bus           : requester / TX-core handshake and status (slave modport)
module uart_tx_arbiter #(
  parameter int P_NUM_REQ      = 3,
  parameter int P_DATA_WIDTH   = 8,
  parameter int P_BURST_MAX    = 4,
  parameter int P_IDLE_TIMEOUT = 16
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  uart_tx_arbiter_if.slave   bus
);

  localparam int          W_IDX  = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
  localparam int unsigned NREQ_U = P_NUM_REQ;

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t                  state;
  logic [W_IDX-1:0]        rr_ptr;
  logic [P_NUM_REQ-1:0]    grant;
  logic [7:0]              burst_cnt;
  logic [7:0]              idle_cnt;
  logic                    tx_valid;
  logic [P_DATA_WIDTH-1:0] tx_data;
  logic                    timeout;

  logic                    pick_found;
  logic [W_IDX-1:0]        pick_idx;
  logic [W_IDX-1:0]        cand_idx;
  int unsigned             cand;

  logic                    out_free;
  logic                    g_valid;
  logic                    g_last;
  logic [P_DATA_WIDTH-1:0] g_data;
  logic                    accept;
  logic                    burst_done;

  // Round-robin search starting just above the last grantee.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 1; i <= NREQ_U; i++) begin
      cand     = (32'(rr_ptr) + i) % NREQ_U;
      cand_idx = W_IDX'(cand);
      if (!pick_found && bus.i_req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // rr_ptr always holds the current grantee while in GRANT.
  assign out_free   = ~tx_valid | bus.i_tx_ready;
  assign g_valid    = bus.i_req_valid[rr_ptr];
  assign g_last     = bus.i_req_last[rr_ptr];
  assign g_data     = bus.i_req_data[rr_ptr*P_DATA_WIDTH +: P_DATA_WIDTH];
  assign accept     = (state == ST_GRANT) && g_valid && out_free;
  assign burst_done = (burst_cnt + 8'd1) == 8'(P_BURST_MAX);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state     <= ST_IDLE;
      rr_ptr    <= W_IDX'(P_NUM_REQ - 1);
      grant     <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;

      // A new accept reloads the stage on the same edge a pending byte leaves.
      if (accept) begin
        tx_valid <= 1'b1;
        tx_data  <= g_data;
      end else if (bus.i_tx_ready) begin
        tx_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            state  <= ST_GRANT;
            rr_ptr <= pick_idx;
            grant  <= {{(P_NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          end
        end
        ST_GRANT: begin
          if (accept) begin
            idle_cnt <= '0;
            if (g_last || burst_done) begin
              state     <= ST_IDLE;
              grant     <= '0;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + 8'd1;
            end
          end else if (!g_valid) begin
            // Count only cycles the grantee has nothing to offer; a stalled
            // output stage with valid held high does not age the grant.
            if (idle_cnt == 8'(P_IDLE_TIMEOUT - 1)) begin
              state     <= ST_IDLE;
              grant     <= '0;
              burst_cnt <= '0;
              idle_cnt  <= '0;
              timeout   <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = ((state == ST_GRANT) && out_free) ? grant : '0;
  assign bus.o_tx_valid  = tx_valid;
  assign bus.o_tx_data   = tx_data;
  assign bus.o_grant     = grant;
  assign bus.o_busy      = (state == ST_GRANT) || tx_valid;
  assign bus.o_timeout   = timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed scenarios plus randomized traffic for uart_tx_arbiter, checked
//   every cycle against a transaction-level reference model of the
//   arbitration rules (owner index, rotation pointer, byte/idle counts).
module tb_uart_tx_arbiter;

  localparam int N    = 3;
  localparam int W    = 8;
  localparam int BMAX = 4;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.P_NUM_REQ(N), .P_DATA_WIDTH(W)) bus ();

  uart_tx_arbiter #(
    .P_NUM_REQ(N), .P_DATA_WIDTH(W), .P_BURST_MAX(BMAX), .P_IDLE_TIMEOUT(TMO)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .bus           (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  logic [8:0]   q [N][$];      // {last, data} per requester
  logic [N-1:0] gate;
  logic         tx_ready;

  // reference model
  int         m_owner, m_rr, m_burst, m_idle;
  logic       m_txv, m_timeout;
  logic [7:0] m_txd;

  // snapshot of DUT outputs taken mid-cycle
  logic [N-1:0] s_grant, s_ready, s_hs;
  logic         s_txv, s_busy, s_timeout;
  logic [7:0]   s_txd;
  logic [7:0]   tx_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = N - 1; m_burst = 0; m_idle = 0;
    m_txv = 1'b0; m_txd = 8'h00; m_timeout = 1'b0;
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic last);
    q[k].push_back({last, d});
  endtask

  task automatic drive();
    logic [N*W-1:0] d;
    logic [N-1:0]   v, l;
    for (int k = 0; k < N; k++) begin
      if (q[k].size() > 0) begin
        v[k] = gate[k];
        d[k*W +: W] = q[k][0][7:0];
        l[k] = q[k][0][8];
      end else begin
        v[k] = 1'b0;
        d[k*W +: W] = 8'($urandom);
        l[k] = 1'($urandom);
      end
    end
    bus.i_req_valid = v;
    bus.i_req_data  = d;
    bus.i_req_last  = l;
    bus.i_tx_ready  = tx_ready;
  endtask

  task automatic cycle();
    logic [N-1:0] exp_ready, exp_grant;
    logic         hs, acc, found;
    int           c;
    @(negedge clk);
    s_grant = bus.o_grant; s_ready = bus.o_req_ready; s_txv = bus.o_tx_valid;
    s_txd = bus.o_tx_data; s_busy = bus.o_busy; s_timeout = bus.o_timeout;
    s_hs = bus.i_req_valid & bus.o_req_ready;

    exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    exp_ready = (m_owner >= 0 && (!m_txv || tx_ready)) ? exp_grant : '0;
    check("grant",   s_grant,   exp_grant);
    check("ready",   s_ready,   exp_ready);
    check("tx_valid", s_txv,    m_txv);
    check("tx_data", s_txd,     m_txd);
    check("busy",    s_busy,    (m_owner >= 0) || m_txv);
    check("timeout", s_timeout, m_timeout);
    if (s_txv && tx_ready) tx_log.push_back(s_txd);

    hs = m_txv && tx_ready;
    m_timeout = 1'b0;
    if (m_owner < 0) begin
      if (hs) m_txv = 1'b0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_rr + k) % N;
        if (!found && bus.i_req_valid[c]) begin
          found = 1'b1; m_owner = c; m_rr = c;
        end
      end
    end else begin
      acc = bus.i_req_valid[m_owner] && exp_ready[m_owner];
      if (acc) begin
        m_txv = 1'b1;
        m_txd = bus.i_req_data[m_owner*W +: W];
        m_burst++;
        m_idle = 0;
        if (bus.i_req_last[m_owner] || m_burst == BMAX) begin
          m_owner = -1; m_burst = 0;
        end
      end else begin
        if (hs) m_txv = 1'b0;
        if (!bus.i_req_valid[m_owner]) begin
          m_idle++;
          if (m_idle == TMO) begin
            m_owner = -1; m_idle = 0; m_burst = 0; m_timeout = 1'b1;
          end
        end
      end
    end

    @(posedge clk); #1;
    for (int k = 0; k < N; k++) if (s_hs[k]) void'(q[k].pop_front());
    drive();
  endtask

  task automatic clear_queues();
    for (int k = 0; k < N; k++) q[k].delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_queues();
    model_reset();
    gate = '1;
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive();
  endtask

  initial begin
    int n;
    gate = '1;
    tx_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    cycle();
    check("rst_grant", s_grant, 0);
    check("rst_txv",   s_txv,   0);
    check("rst_busy",  s_busy,  0);

    // single requester, two-byte packet
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b1); drive();
    cycle();
    cycle(); check("single_grant", s_grant, 3'b001);
    cycle(); check("single_b0", s_txd, 8'h41); check("single_v0", s_txv, 1);
    cycle(); check("single_b1", s_txd, 8'h42); check("single_rel", s_grant, 3'b000);
    repeat (3) cycle();

    // round robin from reset, then rotation after req2 was served
    do_reset();
    tx_log.delete();
    push(0, 8'hA0, 1'b1); push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1); drive();
    repeat (12) cycle();
    check("rr_cnt", tx_log.size(), 3);
    if (tx_log.size() == 3) begin
      check("rr_0", tx_log[0], 8'hA0); check("rr_1", tx_log[1], 8'hA1); check("rr_2", tx_log[2], 8'hA2);
    end
    tx_log.delete();
    push(1, 8'hB1, 1'b1); push(0, 8'hB0, 1'b1); drive();
    repeat (10) cycle();
    check("rr2_cnt", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      check("rr2_0", tx_log[0], 8'hB0); check("rr2_1", tx_log[1], 8'hB1);
    end

    // burst limit forces rotation to pending req2
    tx_log.delete();
    for (int i = 0; i < 6; i++) push(1, 8'(8'h10 + i), i == 5);
    drive();
    cycle();
    push(2, 8'hC2, 1'b1); drive();
    repeat (25) cycle();
    begin
      logic [7:0] exp_b [7];
      exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hC2, 8'h14, 8'h15};
      check("burst_cnt", tx_log.size(), 7);
      if (tx_log.size() == 7)
        for (int i = 0; i < 7; i++) check("burst_seq", tx_log[i], exp_b[i]);
    end

    // output backpressure
    tx_log.delete();
    tx_ready = 1'b0;
    push(0, 8'h60, 1'b0); push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b1); drive();
    n = 0;
    do begin cycle(); n++; end while (!s_txv && n < 10);
    check("bp_bound", n < 10, 1);
    repeat (5) begin
      cycle();
      check("bp_data", s_txd, 8'h60);
      check("bp_ready", s_ready, 0);
      check("bp_timeout", s_timeout, 0);
    end
    tx_ready = 1'b1; drive();
    repeat (8) cycle();
    check("bp_cnt", tx_log.size(), 3);
    if (tx_log.size() == 3) begin
      check("bp_0", tx_log[0], 8'h60); check("bp_1", tx_log[1], 8'h61); check("bp_2", tx_log[2], 8'h62);
    end

    // idle timeout, pending req1 granted next
    tx_log.delete();
    push(0, 8'h55, 1'b0); drive();
    n = 0;
    do begin cycle(); n++; end while (!s_hs[0] && n < 10);
    check("to_acc_bound", n < 10, 1);
    push(1, 8'h99, 1'b1); drive();
    n = 0;
    do begin cycle(); n++; end while (!s_timeout && n < 40);
    check("to_delay", n, 17);
    check("to_grant", s_grant, 0);
    repeat (6) cycle();
    check("to_cnt", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      check("to_0", tx_log[0], 8'h55); check("to_1", tx_log[1], 8'h99);
    end

    // asynchronous reset with a byte held in the output stage
    tx_ready = 1'b0;
    push(0, 8'h7E, 1'b0); push(0, 8'h7F, 1'b1); drive();
    n = 0;
    do begin cycle(); n++; end while (!s_txv && n < 10);
    check("ar_bound", n < 10, 1);
    check("ar_held", s_txd, 8'h7E);
    #2 rst_n = 1'b0;
    #1;
    check("ar_txv",   bus.o_tx_valid,  0);
    check("ar_txd",   bus.o_tx_data,   0);
    check("ar_grant", bus.o_grant,     0);
    check("ar_ready", bus.o_req_ready, 0);
    check("ar_busy",  bus.o_busy,      0);
    check("ar_to",    bus.o_timeout,   0);
    clear_queues();
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    tx_ready = 1'b1;
    tx_log.delete();
    push(1, 8'hD1, 1'b1); push(0, 8'hD0, 1'b1); drive();
    repeat (10) cycle();
    check("ar_cnt", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      check("ar_0", tx_log[0], 8'hD0); check("ar_1", tx_log[1], 8'hD1);
    end

    // randomized traffic against the reference model
    for (int t = 0; t < 800; t++) begin
      for (int k = 0; k < N; k++) begin
        if (q[k].size() < 4 && $urandom_range(0, 7) == 0) begin
          int len;
          logic term;
          len  = $urandom_range(1, 6);
          term = ($urandom_range(0, 4) != 0);
          for (int i = 0; i < len; i++) push(k, 8'($urandom), term && (i == len - 1));
        end
        gate[k] = ($urandom_range(0, 19) != 0);
      end
      tx_ready = ($urandom_range(0, 9) < 7);
      drive();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit byte stream between P_NUM_REQ byte sources, e.g. the AXI-Lite register path, a loopback/echo path and a debug/status message generator.
- Grants one source at a time using round-robin with packet lock.
- Bounds each grant by a burst limit and an idle timeout.
- Drives the TX core through a one-entry registered output stage.
- Sits in the S_AXI_ACLK domain between the requesters and the UART TX core.

Parameters:
- P_NUM_REQ, 3: number of requesters, legal range 2..4.
- P_DATA_WIDTH, 8: byte width; equals `UART_DATA_WIDTH.
- P_BURST_MAX, 4: maximum bytes accepted per grant before forced rotation, legal range 1..255.
- P_IDLE_TIMEOUT, 16: cycles with granted requester's valid low before the grant is revoked, legal range 2..255.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  reset; asynchronous, active-low.
- i_req_valid  in  P_NUM_REQ  per-requester byte valid.
- i_req_data  in  P_NUM_REQ*P_DATA_WIDTH  requester k occupies bits [k*W +: W].
- i_req_last  in  P_NUM_REQ  marks the final byte of a packet; qualified by valid.
- o_req_ready  out  P_NUM_REQ  per-requester ready.
- o_tx_valid  out  1  byte valid to the TX core.
- o_tx_data  out  P_DATA_WIDTH  byte to the TX core.
- i_tx_ready  in  1  TX core accepts when o_tx_valid && i_tx_ready.
- o_grant  out  P_NUM_REQ  one-hot current grant; all zero when idle.
- o_busy  out  1  high in GRANT state or while o_tx_valid is high.
- o_timeout  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: o_tx_valid=0, o_tx_data=0, o_grant=0, o_req_ready=0, o_busy=0, o_timeout=0.
  - Internal: state=IDLE, rr_ptr=P_NUM_REQ-1, burst_cnt=0, idle_cnt=0.
  - A byte held in the output register is discarded.
- FSM states: IDLE, GRANT.
- IDLE:
  - o_req_ready=0.
  - If any i_req_valid is high, select the first set bit searching from rr_ptr+1 upward, modulo P_NUM_REQ.
  - Register the selection into o_grant and rr_ptr; go to GRANT next cycle.
  - No valid high: stay in IDLE.
- GRANT:
  - o_req_ready[g] = ~o_tx_valid | i_tx_ready. This is combinational and applies to the granted bit only; other bits are 0.
  - Accept: i_req_valid[g] && o_req_ready[g]. The byte loads into o_tx_data and o_tx_valid=1 on the next edge.
  - Each accept increments burst_cnt and clears idle_cnt.
- Output stage:
  - o_tx_valid clears after a TX handshake unless a new byte is accepted on the same edge.
  - Full throughput: 1 byte/cycle while i_tx_ready is held high.
- Release from GRANT to IDLE, on the edge after the causing event:
  - (a) accepted byte has i_req_last=1; or
  - (b) the accept makes burst_cnt == P_BURST_MAX; or
  - (c) idle_cnt reaches P_IDLE_TIMEOUT; o_timeout pulses 1 cycle.
  - (a) and (b) on the same byte cause a single release.
  - On release: o_grant=0, burst_cnt=0, idle_cnt=0.
- idle_cnt increments only in GRANT while i_req_valid[g]=0. It holds while stalled by output backpressure (valid high, ready low).
- Latency: requester valid rising with IDLE state and empty output gives o_grant at +1 cycle and o_tx_valid at +2 cycles.
- Re-grant:
  - Minimum one IDLE bubble cycle between grants.
  - A lone requester that hit the burst limit is re-granted after that bubble.
- The output byte may still be pending while the FSM returns to IDLE. The next grantee's ready is gated by the output stage, so no byte is overwritten.
- Requester valid deasserting without a handshake is tolerated. Data of a non-granted requester is ignored.
- Rotation: rr_ptr updates only on grant, so a requester just served has lowest priority next.

Test Plan:
- Single requester: req0 sends 0x41,0x42 (last on 0x42), i_tx_ready=1. Expect o_grant=001 at +1 and o_tx_data 0x41 then 0x42 on consecutive cycles. Expect return to IDLE and o_grant=000 after last.
- Round robin: req0, req1 and req2 each present a 1-byte packet simultaneously from reset. Expect output order 0,1,2 with one IDLE bubble between grants. Then only req1 and req0 re-request: expect req0 before req1, since rr_ptr=2.
- Burst limit: req1 streams 6 bytes 0x10..0x15 with last on 0x15; req2 is pending. Expect 0x10..0x13, then req2's byte, then 0x14,0x15.
- Backpressure: i_tx_ready held low 5 cycles with o_tx_valid=1. Expect o_tx_data stable, o_req_ready=0, no o_timeout. On ready high the transfer completes and the next byte follows.
- Timeout: req0 sends 0x55 without last, then drops valid for 16 cycles. Expect o_timeout pulse on the revoke edge and o_grant=000. A pending req1 is granted next.
- Reset mid-burst: assert S_AXI_ARESETN low while o_tx_valid=1 with data 0x7E. Expect all outputs 0 immediately, not at the next edge. After release, req0 is served first.
